// File: rtl/cam_frame_writer.sv
// cam_frame_writer: buffers captured pixels in a small FIFO and writes each one
// to BASE_ADDR + pixel index over an Avalon write port, one frame at a time.
module cam_frame_writer #(
  parameter logic [28:0] BASE_ADDR    = 29'h0000000,
  parameter int          FRAME_PIXELS = 307200,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ram_rdy,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  input  logic        avl_ready,
  output logic        avl_write_req,
  output logic [28:0] avl_addr,
  output logic [31:0] avl_wdata,
  output logic        frame_done,
  output logic        overflow,
  output logic        frame_err,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] LAST  = CW'(FRAME_PIXELS - 1);
  localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE   = (AW+1)'(1);
  typedef enum logic [1:0] {IDLE, ARM, STREAM, DRAIN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_pix_cnt;
  logic [AW:0] r_wr_ptr, r_rd_ptr, w_cnt, w_rd_sel;
  logic [42:0] r_mem [FIFO_DEPTH];
  logic w_take, w_push, w_abort, w_xfer, w_load, w_fin;
  // The presented write stays in the FIFO until accepted, so occupancy counts it.
  assign w_cnt    = r_wr_ptr - r_rd_ptr;
  assign w_abort  = r_state == STREAM && frame_start;
  assign w_take   = r_state == STREAM && pix_valid && !w_abort;
  assign w_push   = w_take && w_cnt != DEPTH;
  assign w_xfer   = avl_write_req && avl_ready;
  assign w_load   = !w_abort && (avl_write_req ? w_xfer && w_cnt > ONE : w_cnt != '0);
  assign w_rd_sel = w_xfer ? r_rd_ptr + ONE : r_rd_ptr;
  assign w_fin    = r_state == DRAIN && (w_cnt == '0 || (w_xfer && w_cnt == ONE));
  assign busy     = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = enable && ram_rdy ? ARM : IDLE;
      ARM:     w_next = !enable ? IDLE : frame_start ? STREAM : ARM;
      STREAM:  w_next = w_take && r_pix_cnt == LAST ? DRAIN : STREAM;
      DRAIN:   w_next = !w_fin ? DRAIN : enable ? ARM : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {19'(r_pix_cnt), pix_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pix_cnt     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      avl_write_req <= 1'b0;
      avl_addr      <= '0;
      avl_wdata     <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_state       <= w_next;
      frame_done    <= w_fin;
      r_pix_cnt     <= (r_state == ARM || w_abort) ? '0 : w_take ? r_pix_cnt + CW'(1) : r_pix_cnt;
      // An abort keeps only the write already on the bus.
      r_wr_ptr      <= w_abort ? r_rd_ptr + (avl_write_req ? ONE : '0) : w_push ? r_wr_ptr + ONE : r_wr_ptr;
      r_rd_ptr      <= w_xfer ? r_rd_ptr + ONE : r_rd_ptr;
      avl_write_req <= w_load || (avl_write_req && !w_xfer);
      if (w_take && w_cnt == DEPTH) overflow <= 1'b1;
      if (w_abort) frame_err <= 1'b1;
      if (w_load) begin
        avl_addr  <= BASE_ADDR + 29'(r_mem[w_rd_sel[AW-1:0]][42:24]);
        avl_wdata <= {8'h00, r_mem[w_rd_sel[AW-1:0]][23:0]};
      end
    end
  end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: drives a deep-FIFO and a 4-entry-FIFO writer with shared stimulus
// and checks their Avalon writes against a per-frame pixel model.
module tb_cam_frame_writer;
  localparam int FP = 8;
  localparam logic [28:0] BASE = 29'h100;
  typedef struct {int d; logic [28:0] a; logic [31:0] w; int c;} wr_t;
  logic clk = 0, reset = 1, enable = 0, ram_rdy = 0, frame_start = 0, pix_valid = 0, avl_ready = 1;
  logic [23:0] pix_data = '0;
  logic req [2], done [2], ovf [2], err [2], busy [2];
  logic [28:0] addr [2];
  logic [31:0] wdata [2];
  int total = 0, bad = 0, cyc = 0;
  int done_cnt [2] = '{0, 0};
  wr_t log_q [$];
  logic [23:0] px [FP];
  bit rnd = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    cam_frame_writer #(.BASE_ADDR(BASE), .FRAME_PIXELS(FP), .FIFO_DEPTH(g == 0 ? 16 : 4)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .ram_rdy(ram_rdy), .frame_start(frame_start),
      .pix_valid(pix_valid), .pix_data(pix_data), .avl_ready(avl_ready),
      .avl_write_req(req[g]), .avl_addr(addr[g]), .avl_wdata(wdata[g]), .frame_done(done[g]),
      .overflow(ovf[g]), .frame_err(err[g]), .busy(busy[g]));
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (req[d] && avl_ready) log_q.push_back('{d, addr[d], wdata[d], cyc});
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) avl_ready = $urandom_range(0, 3) != 0;
    end
  endtask
  task automatic start_frame;
    frame_start = 1;
    step();
    frame_start = 0;
  endtask
  task automatic push(input logic [23:0] v);
    pix_valid = 1;
    pix_data  = v;
    step();
    pix_valid = 0;
  endtask
  task automatic do_reset;
    reset = 1;
    step(2);
    reset = 0;
    step();
  endtask
  task automatic wait_done(input string tag, input int ea, input int eb);
    int n = 0;
    while ((done_cnt[0] < ea || done_cnt[1] < eb) && n < 400) begin
      step();
      n++;
    end
    step(3);
    check({tag, "_done_a"}, done_cnt[0], ea);
    check({tag, "_done_b"}, done_cnt[1], eb);
  endtask
  // must: pixels that have to be written once; may: pixels that may be written at most once
  task automatic check_writes(input string tag, input int d, input int lo, input int hi,
                              input logic [FP-1:0] must, input logic [FP-1:0] may);
    int seen [FP];
    seen = '{default: 0};
    for (int k = lo; k < hi; k++) begin
      if (log_q[k].d != d) continue;
      check({tag, "_inrange"}, log_q[k].a >= BASE && log_q[k].a < BASE + FP, 1);
      if (log_q[k].a >= BASE && log_q[k].a < BASE + FP) begin
        check({tag, "_wdata"}, log_q[k].w, {8'h00, px[int'(log_q[k].a - BASE)]});
        seen[int'(log_q[k].a - BASE)]++;
      end
    end
    for (int i = 0; i < FP; i++)
      if (may[i] && !must[i]) check({tag, "_dup"}, seen[i] > 1, 0);
      else check({tag, "_cnt"}, seen[i], must[i] ? 1 : 0);
  endtask
  task automatic check_b2b(input string tag, input int d, input int lo, input int n);
    int prev = -1, got = 0;
    for (int k = lo; k < log_q.size() && got < n; k++) if (log_q[k].d == d) begin
      if (prev >= 0) check(tag, log_q[k].c - prev, 1);
      prev = log_q[k].c;
      got++;
    end
    check({tag, "_n"}, got, n);
  endtask
  initial begin
    int mark, mark2, ea, eb;
    step(3);
    for (int d = 0; d < 2; d++) begin
      check("rst_flags", {req[d], done[d], ovf[d], err[d], busy[d]}, 0);
      check("rst_addr", addr[d], 0);
      check("rst_wdata", wdata[d], 0);
    end
    reset = 0;
    enable = 1;
    ram_rdy = 1;
    step();
    check("arm_busy", {busy[0], busy[1]}, 2'b11);
    // basic frame with latency and back-to-back checks
    ea = 1; eb = 1;
    mark = log_q.size();
    for (int i = 0; i < FP; i++) px[i] = 24'(i + 1);
    start_frame();
    for (int k = 0; k < FP; k++) begin
      pix_valid = 1;
      pix_data = px[k];
      step();
      check("lat_a", req[0], k >= 1);
      check("lat_b", req[1], k >= 1);
    end
    pix_valid = 0;
    wait_done("basic", ea, eb);
    for (int d = 0; d < 2; d++) begin
      check_writes("basic", d, mark, log_q.size(), 8'hFF, 8'h00);
      check("basic_ovf", ovf[d], 0);
      check("basic_err", err[d], 0);
    end
    check_b2b("basic_b2b", 0, mark, FP);
    // 6 pixels into a stalled port: the 4-deep writer drops pixels 4 and 5
    do_reset();
    avl_ready = 0;
    mark = log_q.size();
    for (int i = 0; i < FP; i++) px[i] = 24'h100 + 24'(i);
    start_frame();
    for (int k = 0; k < 6; k++) push(px[k]);
    step(2);
    check("ovf_a", ovf[0], 0);
    check("ovf_b", ovf[1], 1);
    avl_ready = 1;
    step(4);
    for (int k = 6; k < FP; k++) push(px[k]);
    ea++; eb++;
    wait_done("ovf", ea, eb);
    check_writes("ovf_a", 0, mark, log_q.size(), 8'hFF, 8'h00);
    check_writes("ovf_b", 1, mark, log_q.size(), 8'b1100_1111, 8'h00);
    // 5-pixel burst held off for 20 cycles
    avl_ready = 0;
    mark = log_q.size();
    for (int i = 0; i < FP; i++) px[i] = 24'(i + 1);
    start_frame();
    for (int k = 0; k < 20; k++) begin
      pix_valid = k < 5;
      pix_data = k < 5 ? px[k] : 24'h0;
      step();
      if (k >= 1) for (int d = 0; d < 2; d++) begin
        check("hold_req", req[d], 1);
        check("hold_addr", addr[d], BASE);
        check("hold_wdata", wdata[d], 32'h1);
      end
    end
    pix_valid = 0;
    avl_ready = 1;
    step(7);
    check_b2b("hold_b2b", 0, mark, 5);
    for (int k = 5; k < FP; k++) push(px[k]);
    ea++; eb++;
    wait_done("hold", ea, eb);
    check_writes("hold_a", 0, mark, log_q.size(), 8'hFF, 8'h00);
    check_writes("hold_b", 1, mark, log_q.size(), 8'b1110_1111, 8'h00);
    check("hold_ovf_a", ovf[0], 0);
    // random frames with random gaps and random backpressure
    rnd = 1;
    for (int f = 0; f < 6; f++) begin
      mark = log_q.size();
      for (int i = 0; i < FP; i++) px[i] = 24'($urandom);
      start_frame();
      for (int k = 0; k < FP; k++) begin
        step($urandom_range(0, 2));
        push(px[k]);
      end
      ea++; eb++;
      wait_done("rnd", ea, eb);
      check_writes("rnd_a", 0, mark, log_q.size(), 8'hFF, 8'h00);
      check_writes("rnd_b", 1, mark, log_q.size(), 8'h00, 8'hFF);
      check("rnd_ovf_a", ovf[0], 0);
    end
    rnd = 0;
    avl_ready = 1;
    // frame_start after 3 of 8 pixels aborts the frame
    do_reset();
    mark = log_q.size();
    for (int i = 0; i < FP; i++) px[i] = 24'hA00 + 24'(i);
    start_frame();
    for (int k = 0; k < 3; k++) push(px[k]);
    start_frame();
    mark2 = log_q.size();
    check("abort_err", {err[0], err[1]}, 2'b11);
    check_writes("abort_old", 0, mark, mark2, 8'h00, 8'h07);
    for (int i = 0; i < FP; i++) px[i] = 24'hB00 + 24'(i);
    for (int k = 0; k < FP; k++) push(px[k]);
    ea++; eb++;
    wait_done("abort", ea, eb);
    for (int d = 0; d < 2; d++) check_writes("abort_new", d, mark2, log_q.size(), 8'hFF, 8'h00);
    // reset while a write is pending, then ram_rdy low holds IDLE
    avl_ready = 0;
    start_frame();
    push(24'h1);
    push(24'h2);
    check("rstw_pre", {req[0], req[1]}, 2'b11);
    reset = 1;
    ram_rdy = 0;
    step();
    for (int d = 0; d < 2; d++) begin
      check("rstw_flags", {req[d], done[d], ovf[d], err[d], busy[d]}, 0);
      check("rstw_addr", addr[d], 0);
    end
    reset = 0;
    avl_ready = 1;
    step(5);
    check("rstw_idle", {busy[0], busy[1], req[0], req[1]}, 0);
    ram_rdy = 1;
    step();
    check("rstw_arm", {busy[0], busy[1]}, 2'b11);
    // enable dropped mid-frame: frame completes, then IDLE
    ea = done_cnt[0]; eb = done_cnt[1];
    mark = log_q.size();
    for (int i = 0; i < FP; i++) px[i] = 24'hC00 + 24'(i);
    start_frame();
    for (int k = 0; k < FP; k++) begin
      if (k == 3) enable = 0;
      push(px[k]);
    end
    ea++; eb++;
    wait_done("en", ea, eb);
    for (int d = 0; d < 2; d++) check_writes("en", d, mark, log_q.size(), 8'hFF, 8'h00);
    check("en_idle", {busy[0], busy[1]}, 0);
    mark = log_q.size();
    start_frame();
    for (int k = 0; k < 4; k++) push(24'hDD);
    step(10);
    check("en_nowrite", log_q.size(), mark);
    check("en_idle2", {busy[0], busy[1]}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
